// File: rtl/mem_port_arbiter.sv
// Four-way round-robin arbiter for one shared memory/bus port.
// One-hot registered grants, registered mux select, and a hold-time watchdog.
module mem_port_arbiter #(
  parameter int HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       ack,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout,
  output logic [1:0] timeout_id
);

  localparam int CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_MAX - 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e        state_q, state_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q;
  logic          to_q, to_d;
  logic [1:0]    tid_q, tid_d;

  logic [2:0]    pick_idle, pick_rel;
  logic [1:0]    rel_ptr;
  logic          hit_last, withdraw, release_now;

  // Returns {found, index} of the first set bit searching p, p+1, p+2, p+3 mod 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign rel_ptr     = sel_q + 2'd1;
  assign pick_idle   = rr_pick(req, ptr_q);
  assign pick_rel    = rr_pick(req & ~(4'b0001 << sel_q), rel_ptr);
  assign hit_last    = (cnt_q == CNT_LAST);
  assign withdraw    = !req[sel_q];
  assign release_now = ack || withdraw || hit_last;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    tid_d   = tid_q;
    case (state_q)
      IDLE: begin
        if (pick_idle[2]) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << pick_idle[1:0];
          sel_d   = pick_idle[1:0];
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          ptr_d = rel_ptr;
          cnt_d = '0;
          if (pick_rel[2]) begin
            gnt_d = 4'b0001 << pick_rel[1:0];
            sel_d = pick_rel[1:0];
          end else if (!withdraw) begin
            // Sole remaining requester keeps the port with a fresh hold window.
            gnt_d = gnt_q;
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
          end
          if (hit_last && !ack && !withdraw) begin
            to_d  = 1'b1;
            tid_d = sel_q;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      to_q    <= 1'b0;
      tid_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      busy_q  <= |gnt_d;
      to_q    <= to_d;
      tid_q   <= tid_d;
    end
  end

  assign gnt        = gnt_q;
  assign sel        = sel_q;
  assign busy       = busy_q;
  assign timeout    = to_q;
  assign timeout_id = tid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at the default hold limit,
// one at HOLD_MAX=4 for the watchdog cases.
module tb_mem_port_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req, req4;
  logic       ack, ack4;
  logic [3:0] gnt, gnt4;
  logic [1:0] sel, sel4;
  logic       busy, busy4;
  logic       timeout, timeout4;
  logic [1:0] tid, tid4;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .ack(ack),
    .gnt(gnt), .sel(sel), .busy(busy), .timeout(timeout), .timeout_id(tid)
  );

  mem_port_arbiter #(.HOLD_MAX(4)) dut4 (
    .clk(clk), .rst(rst), .req(req4), .ack(ack4),
    .gnt(gnt4), .sel(sel4), .busy(busy4), .timeout(timeout4), .timeout_id(tid4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  logic [3:0] rot_exp [5];

  initial begin
    rot_exp[0] = 4'b0001; rot_exp[1] = 4'b0010; rot_exp[2] = 4'b0100;
    rot_exp[3] = 4'b1000; rot_exp[4] = 4'b0001;

    // Reset held two cycles with everything requesting and ack high
    rst = 1'b1; req = 4'b1111; ack = 1'b1; req4 = 4'b0000; ack4 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_gnt", gnt, 4'b0000);
      chk("rst_sel", 4'(sel), 4'd0);
      chk("rst_busy", 4'(busy), 4'd0);
      chk("rst_timeout", 4'(timeout), 4'd0);
      chk("rst_tid", 4'(tid), 4'd0);
    end
    rst = 1'b0; ack = 1'b0;
    step();
    chk("post_rst_gnt", gnt, 4'b0001);
    chk("post_rst_busy", 4'(busy), 4'd1);
    req = 4'b0000;
    step();
    chk("withdraw_idle_gnt", gnt, 4'b0000);

    // ack while idle is ignored
    ack = 1'b1;
    step();
    chk("idle_ack_gnt", gnt, 4'b0000);
    ack = 1'b0;

    // Single requester
    req = 4'b0100;
    step();
    chk("single_gnt", gnt, 4'b0100);
    chk("single_sel", 4'(sel), 4'd2);
    step(); step(); step();
    chk("single_hold_gnt", gnt, 4'b0100);
    ack = 1'b1; req = 4'b0000;
    step();
    chk("single_rel_gnt", gnt, 4'b0000);
    chk("single_rel_sel", 4'(sel), 4'd2);
    chk("single_rel_busy", 4'(busy), 4'd0);
    chk("single_rel_to", 4'(timeout), 4'd0);
    ack = 1'b0;

    // Rotation from a fresh pointer, ack every third cycle
    rst = 1'b1;
    step();
    rst = 1'b0; req = 4'b1111;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("rot_gnt", gnt, rot_exp[i]);
      chk("rot_busy", 4'(busy), 4'd1);
      step();
      chk("rot_hold", gnt, rot_exp[i]);
      step();
      if (i < 4) begin
        ack = 1'b1;
        step();
        ack = 1'b0;
      end
    end
    req = 4'b0000;
    step();
    chk("rot_idle", gnt, 4'b0000);

    // Withdrawal: pointer now 1, requester 1 wins and later drops
    req = 4'b0010;
    step();
    chk("wd_gnt1", gnt, 4'b0010);
    req = 4'b1010;
    step(); step();
    chk("wd_no_preempt", gnt, 4'b0010);
    req = 4'b1000;
    step();
    chk("wd_gnt3", gnt, 4'b1000);
    chk("wd_sel3", 4'(sel), 4'd3);
    chk("wd_to", 4'(timeout), 4'd0);
    req = 4'b0000;
    step();
    chk("wd_idle", gnt, 4'b0000);

    // Reset mid-grant
    req = 4'b0100;
    step();
    chk("mr_gnt2", gnt, 4'b0100);
    step(); step();
    rst = 1'b1; req = 4'b0110;
    step();
    chk("mr_rst_gnt", gnt, 4'b0000);
    chk("mr_rst_busy", 4'(busy), 4'd0);
    rst = 1'b0;
    step();
    chk("mr_after_gnt", gnt, 4'b0010);
    chk("mr_after_sel", 4'(sel), 4'd1);
    req = 4'b0000;
    step();

    // Watchdog at HOLD_MAX=4
    req4 = 4'b0011;
    step();
    chk("wdg_gnt0", gnt4, 4'b0001);
    step(); step(); step();
    chk("wdg_hold4", gnt4, 4'b0001);
    chk("wdg_no_to_yet", 4'(timeout4), 4'd0);
    step();
    chk("wdg_gnt1", gnt4, 4'b0010);
    chk("wdg_to", 4'(timeout4), 4'd1);
    chk("wdg_tid", 4'(tid4), 4'd0);
    step();
    chk("wdg_to_pulse", 4'(timeout4), 4'd0);
    chk("wdg_tid_hold", 4'(tid4), 4'd0);
    step(); step();
    ack4 = 1'b1;
    step();
    chk("wdg_ack_gnt", gnt4, 4'b0001);
    chk("wdg_ack_no_to", 4'(timeout4), 4'd0);
    chk("wdg_ack_tid", 4'(tid4), 4'd0);
    ack4 = 1'b0; req4 = 4'b0000;
    step();
    chk("wdg_idle", gnt4, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
